ufm_writer: RTL and testbench

//  Write-side counterpart of ufm_reader: accepts a byte stream (e.g. from uart rx), buffers 16-byte pages
//  and programs them into MachXO2 UFM through the EFB Wishbone config port (CFGCR 0x70, TXDR 0x71, RXDR 0x73).

---
 rtl/ufm_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ufm_writer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_writer.sv
// ufm_writer: buffers an incoming byte stream into 16-byte pages and programs
// them into MachXO2 UFM through the EFB Wishbone configuration port.
// A session opens transparent configuration, optionally erases the UFM, sets
// the start page, then for each page fills the buffer, programs it and polls
// status, and finally disables configuration and issues bypass.
// The Wishbone bus is driven only while busy is high.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               pulse to begin a session (ignored while busy)
//   data_in/data_valid  stream byte in; data_ready accepts it (FILL only)
//   busy                session in progress, Wishbone owned
//   done                one-cycle pulse on error-free completion
//   error               sticky failure flag, cleared by the next start
//   cyc/stb/we/adr      Wishbone master request
//   data_o/data_i       Wishbone write/read data
//   wb_ack              Wishbone acknowledge
module ufm_writer #(
   parameter int unsigned START_PAGE  = 0,
   parameter int unsigned NUM_PAGES   = 4,
   parameter bit          ERASE_FIRST = 1'b1,
   parameter int unsigned POLL_LIMIT  = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       cyc,
   output logic       stb,
   output logic       we,
   output logic [7:0] adr,
   output logic [7:0] data_o,
   input  logic [7:0] data_i,
   input  logic       wb_ack
);

   localparam logic [7:0]  ADR_CFGCR = 8'h70;
   localparam logic [7:0]  ADR_TXDR  = 8'h71;
   localparam logic [7:0]  ADR_RXDR  = 8'h73;
   localparam logic [13:0] PG        = 14'(START_PAGE);
   localparam logic [10:0] NPG       = 11'(NUM_PAGES);

   typedef enum logic [3:0] {
      S_IDLE, S_OPEN0, S_OPEN, S_ERASE, S_POLL, S_SETADDR,
      S_FILL, S_PROG, S_CLOSE1, S_CLOSE2, S_DONE
   } state_t;

   state_t      state_q;
   logic [4:0]  idx_q;        // access index within the current frame
   logic [3:0]  byte_q;
   logic [10:0] page_q;
   logic [31:0] poll_q;
   logic        after_prog_q; // current busy-wait follows PROG (else ERASE)
   logic        st_busy_q, st_fail_q;
   logic        error_q, cyc_q, we_q;
   logic [7:0]  adr_q, dat_q;
   logic [7:0]  buf_q [16];

   // Access decode for the current frame position. A frame is
   // CFGCR<=0x80, ntx TXDR writes, nrx RXDR reads, CFGCR<=0x00.
   logic [4:0] ntx, nrx, j;
   logic [3:0] pj;
   logic [7:0] tx_byte, acc_adr, acc_dat;
   logic       acc_we, acc_last, st_rd;

   always_comb begin
      ntx     = '0;
      nrx     = '0;
      tx_byte = '0;
      j       = idx_q - 5'd1;
      pj      = idx_q[3:0] - 4'd5;   // buffer index for PROG data bytes
      case (state_q)
         S_OPEN: begin
            ntx = 5'd4;
            if (j == 5'd0) tx_byte = 8'h74;
            else if (j == 5'd1) tx_byte = 8'h08;
         end
         S_ERASE: begin
            ntx = 5'd4;
            if (j == 5'd0) tx_byte = 8'hCB;
         end
         S_POLL: begin
            ntx = 5'd4;
            nrx = 5'd4;
            if (j == 5'd0) tx_byte = 8'h3C;
         end
         S_SETADDR: begin
            ntx = 5'd8;
            case (j)
               5'd0:    tx_byte = 8'hB4;
               5'd4:    tx_byte = 8'h40;
               5'd6:    tx_byte = {2'b00, PG[13:8]};
               5'd7:    tx_byte = PG[7:0];
               default: tx_byte = 8'h00;
            endcase
         end
         S_PROG: begin
            ntx = 5'd20;
            if (j == 5'd0) tx_byte = 8'hC9;
            else if (j == 5'd3) tx_byte = 8'h01;
            else if (j >= 5'd4) tx_byte = buf_q[pj];
         end
         S_CLOSE1: begin
            ntx = 5'd3;
            if (j == 5'd0) tx_byte = 8'h26;
         end
         S_CLOSE2: begin
            ntx     = 5'd4;
            tx_byte = 8'hFF;
         end
         default: ;
      endcase

      acc_we   = 1'b1;
      acc_adr  = ADR_TXDR;
      acc_dat  = tx_byte;
      acc_last = 1'b0;
      if (state_q == S_OPEN0) begin
         // lone CFGCR clear closes any frame left open by an earlier reset
         acc_adr  = ADR_CFGCR;
         acc_dat  = 8'h00;
         acc_last = 1'b1;
      end else if (idx_q == 5'd0) begin
         acc_adr = ADR_CFGCR;
         acc_dat = 8'h80;
      end else if (idx_q <= ntx) begin
         acc_adr = ADR_TXDR;
      end else if (idx_q <= ntx + nrx) begin
         acc_we  = 1'b0;
         acc_adr = ADR_RXDR;
         acc_dat = 8'h00;
      end else begin
         acc_adr  = ADR_CFGCR;
         acc_dat  = 8'h00;
         acc_last = 1'b1;
      end
   end

   // third of the four status reads carries bits 15:8
   assign st_rd = (state_q == S_POLL) && (idx_q == 5'd7);

   // status bits other than BUSY and FAIL carry no meaning here
   logic unused_status;
   assign unused_status = ^{data_i[7:6], data_i[3:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         byte_q       <= '0;
         page_q       <= '0;
         poll_q       <= '0;
         after_prog_q <= 1'b0;
         st_busy_q    <= 1'b0;
         st_fail_q    <= 1'b0;
         error_q      <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         buf_q        <= '{default: '0};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  error_q <= 1'b0;
                  page_q  <= '0;
                  idx_q   <= '0;
                  state_q <= S_OPEN0;
               end
            end
            S_FILL: begin
               if (data_valid) begin
                  buf_q[byte_q] <= data_in;
                  byte_q        <= byte_q + 4'd1;
                  if (byte_q == 4'd15) begin
                     idx_q   <= '0;
                     state_q <= S_PROG;
                  end
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: begin
               // request is launched only from an idle bus cycle, which
               // guarantees at least one low cycle after every ack
               if (!cyc_q) begin
                  cyc_q <= 1'b1;
                  we_q  <= acc_we;
                  adr_q <= acc_adr;
                  dat_q <= acc_dat;
               end else if (wb_ack) begin
                  cyc_q <= 1'b0;
                  we_q  <= 1'b0;
                  adr_q <= '0;
                  dat_q <= '0;
                  if (st_rd) begin
                     st_busy_q <= data_i[4];
                     st_fail_q <= data_i[5];
                  end
                  if (!acc_last) begin
                     idx_q <= idx_q + 5'd1;
                  end else begin
                     idx_q <= '0;
                     case (state_q)
                        S_OPEN0: state_q <= S_OPEN;
                        S_OPEN:  state_q <= ERASE_FIRST ? S_ERASE : S_SETADDR;
                        S_ERASE: begin
                           poll_q       <= '0;
                           after_prog_q <= 1'b0;
                           state_q      <= S_POLL;
                        end
                        S_POLL: begin
                           if (st_fail_q) begin
                              error_q <= 1'b1;
                              state_q <= S_CLOSE1;
                           end else if (st_busy_q) begin
                              if (poll_q + 32'd1 >= POLL_LIMIT) begin
                                 error_q <= 1'b1;
                                 state_q <= S_CLOSE1;
                              end else begin
                                 poll_q <= poll_q + 32'd1;
                              end
                           end else if (after_prog_q) begin
                              page_q <= page_q + 11'd1;
                              byte_q <= '0;
                              state_q <= (page_q + 11'd1 == NPG) ? S_CLOSE1 : S_FILL;
                           end else begin
                              state_q <= S_SETADDR;
                           end
                        end
                        S_SETADDR: begin
                           byte_q  <= '0;
                           state_q <= S_FILL;
                        end
                        S_PROG: begin
                           poll_q       <= '0;
                           after_prog_q <= 1'b1;
                           state_q      <= S_POLL;
                        end
                        S_CLOSE1: state_q <= S_CLOSE2;
                        S_CLOSE2: state_q <= S_DONE;
                        default:  state_q <= S_IDLE;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign data_ready = (state_q == S_FILL);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE) && !error_q;
   assign error      = error_q;
   assign cyc        = cyc_q;
   assign stb        = cyc_q;
   assign we         = we_q;
   assign adr        = adr_q;
   assign data_o     = dat_q;

endmodule

// File: tb/tb_ufm_writer.sv
// tb_ufm_writer: two ufm_writer instances (single-page/no-erase and
// two-page/erase with short poll limit) share one EFB bus model selected by
// sel. Stimulus pushes expected Wishbone accesses into exp_q; the bus model
// pops and compares each access as the DUT presents it, acking after a random
// 0..5 cycle delay and answering status reads from busy_plan/fail_on.
module tb_ufm_writer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0, start = 1'b0, dv = 1'b0, sel = 1'b0;
   logic [7:0] din = '0;
   logic       ack = 1'b0;
   logic [7:0] rdat = '0;

   logic       dr_a, busy_a, done_a, err_a, cyc_a, stb_a, we_a;
   logic [7:0] adr_a, do_a;
   logic       dr_b, busy_b, done_b, err_b, cyc_b, stb_b, we_b;
   logic [7:0] adr_b, do_b;

   ufm_writer #(.START_PAGE(2042), .NUM_PAGES(1), .ERASE_FIRST(1'b0), .POLL_LIMIT(65535)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .data_in(din),
      .data_valid(dv && !sel), .data_ready(dr_a), .busy(busy_a), .done(done_a),
      .error(err_a), .cyc(cyc_a), .stb(stb_a), .we(we_a), .adr(adr_a),
      .data_o(do_a), .data_i(rdat), .wb_ack(ack && !sel));

   ufm_writer #(.START_PAGE(5), .NUM_PAGES(2), .ERASE_FIRST(1'b1), .POLL_LIMIT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .data_in(din),
      .data_valid(dv && sel), .data_ready(dr_b), .busy(busy_b), .done(done_b),
      .error(err_b), .cyc(cyc_b), .stb(stb_b), .we(we_b), .adr(adr_b),
      .data_o(do_b), .data_i(rdat), .wb_ack(ack && sel));

   logic       dr_m, busy_m, done_m, err_m, cyc_m, stb_m, we_m;
   logic [7:0] adr_m, do_m;
   assign dr_m   = sel ? dr_b   : dr_a;
   assign busy_m = sel ? busy_b : busy_a;
   assign done_m = sel ? done_b : done_a;
   assign err_m  = sel ? err_b  : err_a;
   assign cyc_m  = sel ? cyc_b  : cyc_a;
   assign stb_m  = sel ? stb_b  : stb_a;
   assign we_m   = sel ? we_b   : we_a;
   assign adr_m  = sel ? adr_b  : adr_a;
   assign do_m   = sel ? do_b   : do_a;

   int errors = 0;
   int checks = 0;

   logic [16:0] exp_q [$];   // {we, adr, data}; data ignored for reads
   logic [7:0]  fb [$];

   int busy_plan = 0;        // status polls per session answered BUSY
   bit fail_on   = 1'b0;     // answer FAIL on every status read
   bit rst_hit   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   // ---------------- expected traffic ----------------
   task automatic pw(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({1'b1, a, d});
   endtask

   task automatic pr();
      exp_q.push_back({1'b0, 8'h73, 8'h00});
   endtask

   task automatic frame(input int nrx);
      pw(8'h70, 8'h80);
      foreach (fb[i]) pw(8'h71, fb[i]);
      for (int k = 0; k < nrx; k++) pr();
      pw(8'h70, 8'h00);
   endtask

   task automatic e_open();
      pw(8'h70, 8'h00);
      fb = {8'h74, 8'h08, 8'h00, 8'h00};
      frame(0);
   endtask

   task automatic e_erase();
      fb = {8'hCB, 8'h00, 8'h00, 8'h00};
      frame(0);
   endtask

   task automatic e_poll();
      fb = {8'h3C, 8'h00, 8'h00, 8'h00};
      frame(4);
   endtask

   task automatic e_setaddr(input logic [7:0] hi, input logic [7:0] lo);
      fb = {8'hB4, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, hi, lo};
      frame(0);
   endtask

   task automatic e_prog(input logic [7:0] base);
      fb = {8'hC9, 8'h00, 8'h00, 8'h01};
      for (int i = 0; i < 16; i++) fb.push_back(base + 8'(i));
      frame(0);
   endtask

   task automatic e_close();
      fb = {8'h26, 8'h00, 8'h00};
      frame(0);
      fb = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      frame(0);
   endtask

   // ---------------- EFB model + monitor ----------------
   bit          pend = 1'b0;
   int          delay = 0;
   int          rd_n = 0;
   int          st_cnt = 0;
   int          done_tot = 0;
   logic        prev_busy = 1'b0;
   logic [16:0] cur, e;

   always @(negedge clk) begin
      if (busy_m && !prev_busy) st_cnt = 0;
      prev_busy = busy_m;
      if (done_m) done_tot++;

      if (ack) begin
         ack = 1'b0;
         pend = 1'b0;
         chk("wb_gap_after_ack", {30'd0, cyc_m, stb_m}, 32'd0);
      end else if (cyc_m || stb_m) begin
         if (!pend) begin
            pend = 1'b1;
            cur = {we_m, adr_m, do_m};
            chk("wb_cyc_stb", {30'd0, cyc_m, stb_m}, 32'd3);
            chk("ready_low_on_bus", {31'd0, dr_m}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got access %0h, required none", cur);
            end else begin
               e = exp_q.pop_front();
               chk("wb_access", {15'd0, (e[16] ? cur : {cur[16:8], 8'h00})}, {15'd0, e});
            end
            if (we_m && adr_m == 8'h70 && do_m == 8'h80) rd_n = 0;
            delay = $urandom_range(0, 5);
         end else begin
            chk("wb_hold", {13'd0, cyc_m, stb_m, we_m, adr_m, do_m}, {13'd0, 2'b11, cur});
         end
         if (delay == 0) begin
            ack  = 1'b1;
            rdat = 8'h30;   // BUSY|FAIL set in bytes the DUT must ignore
            if (!we_m && adr_m == 8'h73) begin
               if (rd_n == 2) begin
                  if (fail_on) rdat = 8'h20;
                  else if (st_cnt < busy_plan) rdat = 8'h10;
                  else rdat = 8'h00;
                  st_cnt++;
               end
               rd_n++;
            end
         end else begin
            delay--;
         end
      end else if (pend) begin
         pend = 1'b0;
         if (!rst_hit) chk("wb_hold_until_ack", {31'd0, cyc_m}, 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic go();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy_m}, 32'd1);
      chk("error_cleared_on_start", {31'd0, err_m}, 32'd0);
   endtask

   task automatic feed(input logic [7:0] base, input bit toggle);
      int t;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         dv  = 1'b1;
         din = base + 8'(i);
         t = 0;
         while (!dr_m && t < 3000) begin
            @(negedge clk);
            t++;
         end
         if (!dr_m) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: data_ready 0 for byte %0d, required 1", i);
            dv = 1'b0;
            return;
         end
         if (toggle) begin
            @(negedge clk);
            dv = 1'b0;
         end
      end
      @(negedge clk);
      dv = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy_m && t < 6000) begin
         @(negedge clk);
         t++;
      end
      if (busy_m) begin
         checks++;
         errors++;
         $display("FAIL session_timeout: busy 1 after %0d cycles, required 0", t);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic end_checks(input string nm, input int d0, input int want_done, input logic want_err);
      chk({nm, "_all_frames_seen"}, exp_q.size(), 32'd0);
      chk({nm, "_done_pulses"}, done_tot - d0, want_done);
      chk({nm, "_error"}, {31'd0, err_m}, {31'd0, want_err});
      exp_q.delete();
   endtask

   int d0;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs_a", {busy_a, done_a, err_a, cyc_a, stb_a, we_a, dr_a, adr_a, do_a}, 32'd0);
      chk("reset_outputs_b", {busy_b, done_b, err_b, cyc_b, stb_b, we_b, dr_b, adr_b, do_b}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // start together with reset: reset wins
      sel = 1'b0;
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("start_with_reset_busy", {31'd0, busy_a}, 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("start_with_reset_busy_after", {31'd0, busy_a}, 32'd0);

      // reset in the middle of PROG
      e_open(); e_setaddr(8'h07, 8'hFA); e_prog(8'h40); e_poll(); e_close();
      go();
      feed(8'h40, 1'b0);
      repeat (20) @(negedge clk);
      rst_hit = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midprog_reset_quiet", {28'd0, cyc_a, stb_a, busy_a, dr_a}, 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst_hit = 1'b0;

      // single page at 2042, no erase
      d0 = done_tot;
      e_open(); e_setaddr(8'h07, 8'hFA); e_prog(8'h00); e_poll(); e_close();
      go();
      feed(8'h00, 1'b0);
      wait_idle();
      end_checks("single_page", d0, 1, 1'b0);

      // two pages with erase, 3 busy polls, toggling data_valid, start while busy
      sel = 1'b1;
      repeat (2) @(negedge clk);
      busy_plan = 3;
      d0 = done_tot;
      e_open(); e_erase(); e_poll(); e_poll(); e_poll(); e_poll();
      e_setaddr(8'h00, 8'h05);
      e_prog(8'h10); e_poll(); e_prog(8'hA0); e_poll(); e_close();
      go();
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(8'h10, 1'b1);
      feed(8'hA0, 1'b1);
      wait_idle();
      end_checks("two_pages", d0, 1, 1'b0);

      // FAIL status after erase
      busy_plan = 0;
      fail_on = 1'b1;
      d0 = done_tot;
      e_open(); e_erase(); e_poll(); e_close();
      go();
      wait_idle();
      end_checks("erase_fail", d0, 0, 1'b1);
      fail_on = 1'b0;

      // busy for exactly POLL_LIMIT polls
      busy_plan = 4;
      d0 = done_tot;
      e_open(); e_erase(); e_poll(); e_poll(); e_poll(); e_poll(); e_close();
      go();
      wait_idle();
      end_checks("poll_limit", d0, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
